pwm_breath_seq: RTL and testbench



---
 rtl/led_pwm_pkg.sv | 22 ++
 rtl/pwm_breath_seq_wrap_prescaler.sv | 38 +++
 rtl/pwm_breath_seq.sv | 111 +++++++++++
 tb/tb_pwm_breath_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// ============================================================================
// Module   : led_pwm_pkg
// Brief    : Shared state encoding and default sizing for the LED PWM path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pwm_pkg;

    localparam int PWM_PERIOD = 100;
    localparam int DUTY_W     = 8;

    typedef enum logic [1:0] {
        HOLD_LOW  = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD_HIGH = 2'd2,
        RAMP_DOWN = 2'd3
    } breath_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_breath_seq_wrap_prescaler.sv
// ============================================================================
// Module   : wrap_prescaler
// Brief    : Divides accepted PWM wrap pulses down to one sequencer step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pwm_wrap,
    output logic step
);

    localparam int                c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_pre_cnt;
    logic               w_accept;

    // A wrap arriving while disabled is simply lost, never queued.
    assign w_accept = pwm_wrap & en;
    assign step     = w_accept && (r_pre_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_accept) begin
            r_pre_cnt <= step ? '0 : r_pre_cnt + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_breath_seq.sv
// ============================================================================
// Module   : pwm_breath_seq
// Brief    : Triangular "breathing" duty sequencer stepped on PWM wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_breath_seq #(
    parameter int PERIOD     = led_pwm_pkg::PWM_PERIOD,
    parameter int DUTY_W     = led_pwm_pkg::DUTY_W,
    parameter int STEP       = 1,
    parameter int PRESCALE   = 4,
    parameter int HOLD_STEPS = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pwm_wrap,
    input  logic [DUTY_W-1:0] max_duty,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [1:0]        state
);

    import led_pwm_pkg::*;

    localparam int                 c_hold_w    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_STEPS - 1);
    localparam logic [DUTY_W-1:0]   c_period    = DUTY_W'(PERIOD);
    localparam logic [DUTY_W:0]     c_step      = (DUTY_W + 1)'(STEP);

    breath_state_t       r_state, w_state_nxt;
    logic [DUTY_W-1:0]   r_duty, w_duty_nxt, w_max_eff;
    logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
    logic                r_duty_upd;
    logic                w_step;
    logic [DUTY_W:0]     w_sum, w_diff;

    wrap_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pwm_wrap (pwm_wrap),
        .step     (w_step)
    );

    assign w_max_eff = (max_duty > c_period) ? c_period : max_duty;

    // One extra bit so the ramp-up sum cannot wrap before it is clamped.
    assign w_sum  = {1'b0, r_duty} + c_step;
    assign w_diff = ({1'b0, r_duty} > c_step) ? ({1'b0, r_duty} - c_step) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_hold_nxt  = r_hold_cnt;
        if (w_step) begin
            case (r_state)
                HOLD_LOW, HOLD_HIGH: begin
                    if (r_hold_cnt == c_hold_last) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = (r_state == HOLD_LOW) ? RAMP_UP : RAMP_DOWN;
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_hold_w'(1);
                    end
                end
                RAMP_UP: begin
                    // Also covers a duty already above a freshly lowered peak.
                    w_duty_nxt = (w_sum > {1'b0, w_max_eff}) ? w_max_eff : w_sum[DUTY_W-1:0];
                    if (w_duty_nxt == w_max_eff) begin
                        w_state_nxt = HOLD_HIGH;
                        w_hold_nxt  = '0;
                    end
                end
                RAMP_DOWN: begin
                    w_duty_nxt = (w_diff > {1'b0, w_max_eff}) ? w_max_eff : w_diff[DUTY_W-1:0];
                    if (w_duty_nxt == '0) begin
                        w_state_nxt = HOLD_LOW;
                        w_hold_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = HOLD_LOW;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HOLD_LOW;
            r_duty     <= '0;
            r_hold_cnt <= '0;
            r_duty_upd <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_duty_upd <= w_step && (w_duty_nxt != r_duty);
        end
    end

    assign duty     = r_duty;
    assign duty_upd = r_duty_upd;
    assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pwm_breath_seq.sv
// ============================================================================
// Module   : tb_pwm_breath_seq
// Brief    : Self-checking bench; duty_upd pulses are matched against a queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_breath_seq;

    import led_pwm_pkg::*;

    typedef struct packed {
        logic [7:0] duty;
        logic [1:0] st;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       pwm_wrap;
    logic [7:0] max_duty;
    logic [7:0] duty;
    logic       duty_upd;
    logic [1:0] state;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    exp_t exp_q[$];
    exp_t e;

    pwm_breath_seq #(
        .PERIOD     (100),
        .DUTY_W     (8),
        .STEP       (10),
        .PRESCALE   (2),
        .HOLD_STEPS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pwm_wrap (pwm_wrap),
        .max_duty (max_duty),
        .duty     (duty),
        .duty_upd (duty_upd),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every duty_upd pulse must match the next queued (duty, state) pair.
    always @(negedge clk) begin
        if (duty_upd === 1'b1) begin
            n_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_duty_upd: got duty=%0d state=%0d, required no pulse", duty, state);
            end else begin
                e = exp_q.pop_front();
                if (duty !== e.duty || state !== e.st) begin
                    n_fail++;
                    $display("FAIL scoreboard: got duty=%0d state=%0d, required duty=%0d state=%0d",
                             duty, state, e.duty, e.st);
                end
            end
        end
    end

    task automatic push(input int d, input logic [1:0] s);
        exp_t x;
        x.duty = 8'(d);
        x.st   = s;
        exp_q.push_back(x);
    endtask

    // Called at posedge+1; one pwm_wrap pulse, 101 clocks per call.
    task automatic wrap();
        pwm_wrap = 1'b1;
        @(posedge clk);
        #1;
        pwm_wrap = 1'b0;
        repeat (100) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (duty !== 8'd0 || duty_upd !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: got duty=%0d upd=%0b state=%0d, required 0/0/0", duty, duty_upd, state);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_cycle();
        do_reset();
        n_pulses = 0;
        for (int d = 10; d <= 90; d += 10) push(d, RAMP_UP);
        push(100, HOLD_HIGH);
        for (int d = 90; d >= 10; d -= 10) push(d, RAMP_DOWN);
        push(0, HOLD_LOW);
        for (int w = 1; w <= 52; w++) begin
            wrap();
            if (w == 5) begin
                n_checks++;
                if (state !== HOLD_LOW) begin
                    n_fail++;
                    $display("FAIL full_w5_state: got %0d, required %0d", state, HOLD_LOW);
                end
            end
            if (w == 6) begin
                n_checks++;
                if (state !== RAMP_UP || duty !== 8'd0) begin
                    n_fail++;
                    $display("FAIL full_w6: got state=%0d duty=%0d, required 1/0", state, duty);
                end
            end
            if (w == 7) begin
                n_checks++;
                if (duty !== 8'd0) begin
                    n_fail++;
                    $display("FAIL full_w7_duty: got %0d, required 0", duty);
                end
            end
            if (w == 26) begin
                n_checks++;
                if (state !== HOLD_HIGH || duty !== 8'd100) begin
                    n_fail++;
                    $display("FAIL full_w26: got state=%0d duty=%0d, required 2/100", state, duty);
                end
            end
            if (w == 32) begin
                n_checks++;
                if (state !== RAMP_DOWN || duty !== 8'd100) begin
                    n_fail++;
                    $display("FAIL full_w32: got state=%0d duty=%0d, required 3/100", state, duty);
                end
            end
            if (w == 52) begin
                n_checks++;
                if (state !== HOLD_LOW || duty !== 8'd0) begin
                    n_fail++;
                    $display("FAIL full_w52: got state=%0d duty=%0d, required 0/0", state, duty);
                end
            end
        end
        n_checks++;
        if (n_pulses != 20) begin
            n_fail++;
            $display("FAIL full_pulse_count: got %0d, required 20", n_pulses);
        end
        check_drained("full");
    endtask

    task automatic test_peak_clamp();
        max_duty = 8'd35;
        do_reset();
        push(10, RAMP_UP);
        push(20, RAMP_UP);
        push(30, RAMP_UP);
        push(35, HOLD_HIGH);
        repeat (14) wrap();
        n_checks++;
        if (state !== HOLD_HIGH || duty !== 8'd35) begin
            n_fail++;
            $display("FAIL peak35: got state=%0d duty=%0d, required 2/35", state, duty);
        end
        check_drained("peak35");

        max_duty = 8'd200;
        do_reset();
        for (int d = 10; d <= 90; d += 10) push(d, RAMP_UP);
        push(100, HOLD_HIGH);
        repeat (28) wrap();
        n_checks++;
        if (state !== HOLD_HIGH || duty !== 8'd100) begin
            n_fail++;
            $display("FAIL peak200: got state=%0d duty=%0d, required 2/100", state, duty);
        end
        check_drained("peak200");
        max_duty = 8'd100;
    endtask

    task automatic test_lower_peak_in_hold();
        max_duty = 8'd100;
        do_reset();
        for (int d = 10; d <= 90; d += 10) push(d, RAMP_UP);
        push(100, HOLD_HIGH);
        repeat (26) wrap();
        max_duty = 8'd25;
        repeat (6) wrap();
        n_checks++;
        if (state !== RAMP_DOWN || duty !== 8'd100) begin
            n_fail++;
            $display("FAIL lower_hold: got state=%0d duty=%0d, required 3/100", state, duty);
        end
        push(25, RAMP_DOWN);
        push(15, RAMP_DOWN);
        push(5, RAMP_DOWN);
        push(0, HOLD_LOW);
        repeat (8) wrap();
        n_checks++;
        if (state !== HOLD_LOW || duty !== 8'd0) begin
            n_fail++;
            $display("FAIL lower_end: got state=%0d duty=%0d, required 0/0", state, duty);
        end
        check_drained("lower");
        max_duty = 8'd100;
    endtask

    task automatic test_enable_freeze();
        do_reset();
        for (int d = 10; d <= 40; d += 10) push(d, RAMP_UP);
        repeat (14) wrap();
        en = 1'b0;
        repeat (5) wrap();
        n_checks++;
        if (state !== RAMP_UP || duty !== 8'd40) begin
            n_fail++;
            $display("FAIL freeze: got state=%0d duty=%0d, required 1/40", state, duty);
        end
        en = 1'b1;
        push(50, RAMP_UP);
        wrap();
        n_checks++;
        if (duty !== 8'd40) begin
            n_fail++;
            $display("FAIL resume_first_wrap: got duty=%0d, required 40", duty);
        end
        wrap();
        n_checks++;
        if (duty !== 8'd50) begin
            n_fail++;
            $display("FAIL resume_second_wrap: got duty=%0d, required 50", duty);
        end
        check_drained("freeze");
    endtask

    task automatic test_reset_with_wrap();
        do_reset();
        for (int d = 10; d <= 90; d += 10) push(d, RAMP_UP);
        push(100, HOLD_HIGH);
        for (int d = 90; d >= 60; d -= 10) push(d, RAMP_DOWN);
        repeat (41) wrap();
        n_checks++;
        if (state !== RAMP_DOWN || duty !== 8'd60) begin
            n_fail++;
            $display("FAIL pre_rst: got state=%0d duty=%0d, required 3/60", state, duty);
        end
        rst      = 1'b1;
        pwm_wrap = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        pwm_wrap = 1'b0;
        n_checks++;
        if (duty !== 8'd0 || state !== HOLD_LOW || duty_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wrap: got duty=%0d state=%0d upd=%0b, required 0/0/0", duty, state, duty_upd);
        end
        push(10, RAMP_UP);
        for (int w = 1; w <= 8; w++) begin
            wrap();
            if (w == 5) begin
                n_checks++;
                if (state !== HOLD_LOW) begin
                    n_fail++;
                    $display("FAIL rst_resume_w5: got state=%0d, required 0", state);
                end
            end
            if (w == 6) begin
                n_checks++;
                if (state !== RAMP_UP) begin
                    n_fail++;
                    $display("FAIL rst_resume_w6: got state=%0d, required 1", state);
                end
            end
            if (w == 8) begin
                n_checks++;
                if (duty !== 8'd10) begin
                    n_fail++;
                    $display("FAIL rst_resume_w8: got duty=%0d, required 10", duty);
                end
            end
        end
        check_drained("rst_wrap");
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        pwm_wrap = 1'b0;
        max_duty = 8'd100;
        test_reset();
        test_full_cycle();
        test_peak_clamp();
        test_lower_peak_in_hold();
        test_enable_freeze();
        test_reset_with_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
